id_ex_skid: RTL and testbench

ID_EX_SKID -- requirements
Module: id_ex_skid

---
 rtl/id_ex_skid_pkg.sv | 23 ++
 rtl/id_ex_skid_br_tgt_calc.sv | 19 +
 rtl/id_ex_skid.sv | 113 +++++++++++
 tb/tb_id_ex_skid.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_skid_pkg.sv
// Shared pipeline definitions for the decode-to-execute skid stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: skid occupancy state encoding, opcode field location, bubble test helper.
package id_ex_skid_pkg;

    // Encoding equals the entry count, so occ can be taken straight from state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

    // Opcode sits in the least significant bits of every payload.
    localparam int OPC_LSB = 0;
    localparam int OPC_W   = 7;

    // A zero opcode marks a bubble that must not occupy an entry.
    function automatic logic is_bubble(input logic [OPC_W-1:0] opc);
        return (opc == '0);
    endfunction

endpackage

// File: rtl/id_ex_skid_br_tgt_calc.sv
// Branch target adder: (pc + off) modulo 2^XLEN with bit 0 cleared.
// Latency: combinational; the caller registers the result.
// Backpressure: none, evaluated every cycle.
// Ports: i_pc, i_off (XLEN) in; o_tgt (XLEN) out.
module br_tgt_calc #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_off,
    output logic [XLEN-1:0] o_tgt
);

    logic [XLEN-1:0] w_sum;

    // Carry out of the top bit is dropped, giving the modulo wrap.
    assign w_sum = i_pc + i_off;
    assign o_tgt = w_sum & {{(XLEN-1){1'b1}}, 1'b0};

endmodule

// File: rtl/id_ex_skid.sv
// ID/EX pipeline stage: 2-entry skid buffer (main + skid) plus a registered branch-target path.
// Latency: one cycle from push to out_data when empty or popping; branch target one cycle.
// Backpressure: in_ready is registered state only (low while both entries are held), never from out_ready.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data from decode; out_valid/out_ready/out_data
//        to execute; flush; occ (0..2); br_en/br_pc/br_off in; br_tgt/br_tgt_vld out.
module id_ex_skid
    import id_ex_skid_pkg::*;
#(
    parameter int DW   = 78,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    input  logic            flush,
    output logic [1:0]      occ,
    input  logic            br_en,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_off,
    output logic [XLEN-1:0] br_tgt,
    output logic            br_tgt_vld
);

    skid_state_t     r_state;
    logic [DW-1:0]   r_main;
    logic [DW-1:0]   r_skid;
    logic [XLEN-1:0] r_br_tgt;
    logic            r_br_tgt_vld;

    logic            w_push;
    logic            w_store;
    logic            w_pop;
    logic [XLEN-1:0] w_br_tgt;

    assign in_ready  = (r_state != ST_TWO);
    assign out_valid = (r_state != ST_EMPTY);
    // r_main is kept zero whenever it is not valid, so bubbles show as opcode 0.
    assign out_data  = r_main;
    assign occ       = r_state;

    assign w_push  = in_valid && in_ready;
    // Bubble payloads complete the handshake but never take an entry.
    assign w_store = w_push && !is_bubble(in_data[OPC_LSB +: OPC_W]);
    assign w_pop   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_store) begin
                        r_main  <= in_data;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_store && w_pop) begin
                        r_main <= in_data;
                    end else if (w_store) begin
                        r_skid  <= in_data;
                        r_state <= ST_TWO;
                    end else if (w_pop) begin
                        r_main  <= '0;
                        r_state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        r_main  <= r_skid;
                        r_skid  <= '0;
                        r_state <= ST_ONE;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_main  <= '0;
                    r_skid  <= '0;
                end
            endcase
        end
    end

    br_tgt_calc #(
        .XLEN (XLEN)
    ) u_br_tgt_calc (
        .i_pc  (br_pc),
        .i_off (br_off),
        .o_tgt (w_br_tgt)
    );

    // Branch path is independent of flush and of the skid state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_br_tgt     <= '0;
            r_br_tgt_vld <= 1'b0;
        end else begin
            r_br_tgt     <= w_br_tgt;
            r_br_tgt_vld <= br_en;
        end
    end

    assign br_tgt     = r_br_tgt;
    assign br_tgt_vld = r_br_tgt_vld;

endmodule

// File: tb/tb_id_ex_skid.sv
module tb_id_ex_skid;

    localparam int DW   = 78;
    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            flush;
    logic [1:0]      occ;
    logic            br_en;
    logic [XLEN-1:0] br_pc;
    logic [XLEN-1:0] br_off;
    logic [XLEN-1:0] br_tgt;
    logic            br_tgt_vld;

    int n_cmp;
    int n_err;

    id_ex_skid #(.DW(DW), .XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flush      (flush),
        .occ        (occ),
        .br_en      (br_en),
        .br_pc      (br_pc),
        .br_off     (br_off),
        .br_tgt     (br_tgt),
        .br_tgt_vld (br_tgt_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        br_en     = 1'b0;
        br_pc     = '0;
        br_off    = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_cmp++; if (occ !== 2'd0)      begin n_err++; $display("FAIL reset_occ: got %0d want 0", occ); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== '0)   begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (br_tgt !== '0)     begin n_err++; $display("FAIL reset_br_tgt: got %h want 0", br_tgt); end
        n_cmp++; if (br_tgt_vld !== 1'b0) begin n_err++; $display("FAIL reset_br_tgt_vld: got %b want 0", br_tgt_vld); end
    endtask

    task automatic test_streaming();
        logic [DW-1:0] vals [3];
        vals[0] = 78'h11; vals[1] = 78'h22; vals[2] = 78'h33;
        idle_inputs();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = vals[i];
            step();
            n_cmp++; if (out_data !== vals[i]) begin n_err++; $display("FAIL stream_data[%0d]: got %h want %h", i, out_data, vals[i]); end
            n_cmp++; if (occ !== 2'd1)         begin n_err++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, occ); end
            n_cmp++; if (out_valid !== 1'b1)   begin n_err++; $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid); end
        end
        in_valid = 1'b0;
        in_data  = '0;
        step();
        n_cmp++; if (occ !== 2'd0)       begin n_err++; $display("FAIL stream_drain_occ: got %0d want 0", occ); end
        n_cmp++; if (out_data !== '0)    begin n_err++; $display("FAIL stream_drain_data: got %h want 0", out_data); end
    endtask

    task automatic test_backpressure();
        idle_inputs();
        in_valid = 1'b1; in_data = 78'h11;
        step();
        in_data = 78'h22;
        step();
        in_valid = 1'b0; in_data = '0;
        n_cmp++; if (occ !== 2'd2)          begin n_err++; $display("FAIL bp_occ_full: got %0d want 2", occ); end
        n_cmp++; if (in_ready !== 1'b0)     begin n_err++; $display("FAIL bp_in_ready_full: got %b want 0", in_ready); end
        n_cmp++; if (out_data !== 78'h11)   begin n_err++; $display("FAIL bp_head: got %h want 11", out_data); end
        // A held offer while full must not displace anything.
        in_valid = 1'b1; in_data = 78'h99;
        step();
        in_valid = 1'b0; in_data = '0;
        n_cmp++; if (out_data !== 78'h11)   begin n_err++; $display("FAIL bp_hold: got %h want 11", out_data); end
        n_cmp++; if (occ !== 2'd2)          begin n_err++; $display("FAIL bp_hold_occ: got %0d want 2", occ); end
        out_ready = 1'b1;
        step();
        n_cmp++; if (out_data !== 78'h22)   begin n_err++; $display("FAIL bp_second: got %h want 22", out_data); end
        n_cmp++; if (in_ready !== 1'b1)     begin n_err++; $display("FAIL bp_in_ready_back: got %b want 1", in_ready); end
        n_cmp++; if (occ !== 2'd1)          begin n_err++; $display("FAIL bp_occ_one: got %0d want 1", occ); end
        step();
        n_cmp++; if (out_valid !== 1'b0)    begin n_err++; $display("FAIL bp_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        idle_inputs();
        in_valid = 1'b1; in_data = 78'h55;
        step();
        in_data = 78'h66;
        step();
        n_cmp++; if (occ !== 2'd2) begin n_err++; $display("FAIL flush_setup_occ: got %0d want 2", occ); end
        flush = 1'b1; in_data = 78'h44; out_ready = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++; if (occ !== 2'd0)       begin n_err++; $display("FAIL flush_two_occ: got %0d want 0", occ); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_two_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== '0)    begin n_err++; $display("FAIL flush_two_data: got %h want 0", out_data); end
        // Flush in ONE with an accepted push: the push must be discarded.
        out_ready = 1'b0; in_data = 78'h77;
        step();
        flush = 1'b1; in_data = 78'h44; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; in_data = '0;
        n_cmp++; if (occ !== 2'd0) begin n_err++; $display("FAIL flush_one_occ: got %0d want 0", occ); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (out_valid !== 1'b0 || out_data === 78'h44)
                begin n_err++; $display("FAIL flush_no_emit[%0d]: valid %b data %h want 0/0", i, out_valid, out_data); end
        end
    endtask

    task automatic test_bubble();
        idle_inputs();
        in_valid = 1'b1; in_data = 78'h80;
        step();
        n_cmp++; if (occ !== 2'd0)       begin n_err++; $display("FAIL bubble_empty_occ: got %0d want 0", occ); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bubble_empty_valid: got %b want 0", out_valid); end
        in_data = 78'h11;
        step();
        in_data = 78'h100;
        step();
        n_cmp++; if (occ !== 2'd1)        begin n_err++; $display("FAIL bubble_one_occ: got %0d want 1", occ); end
        n_cmp++; if (out_data !== 78'h11) begin n_err++; $display("FAIL bubble_one_data: got %h want 11", out_data); end
        // Pop together with a bubble push leaves the stage empty.
        out_ready = 1'b1;
        step();
        in_valid = 1'b0; in_data = '0;
        n_cmp++; if (occ !== 2'd0)       begin n_err++; $display("FAIL bubble_pop_occ: got %0d want 0", occ); end
    endtask

    task automatic test_branch();
        idle_inputs();
        br_en = 1'b1; br_pc = 32'h0000_1000; br_off = 32'h0000_0007;
        step();
        n_cmp++; if (br_tgt !== 32'h0000_1006) begin n_err++; $display("FAIL br_tgt_basic: got %h want 00001006", br_tgt); end
        n_cmp++; if (br_tgt_vld !== 1'b1)      begin n_err++; $display("FAIL br_vld_basic: got %b want 1", br_tgt_vld); end
        // Wrap case, with flush asserted to show the branch path ignores it.
        br_en = 1'b0; br_pc = 32'hFFFF_FFFC; br_off = 32'h0000_0008; flush = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++; if (br_tgt !== 32'h0000_0004) begin n_err++; $display("FAIL br_tgt_wrap: got %h want 00000004", br_tgt); end
        n_cmp++; if (br_tgt_vld !== 1'b0)      begin n_err++; $display("FAIL br_vld_drop: got %b want 0", br_tgt_vld); end
        br_en = 1'b1; br_pc = 32'h0000_2001; br_off = 32'h0000_0002;
        step();
        n_cmp++; if (br_tgt !== 32'h0000_2002) begin n_err++; $display("FAIL br_tgt_odd: got %h want 00002002", br_tgt); end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        in_valid = 1'b1; in_data = 78'h11;
        step();
        in_data = 78'h22;
        step();
        n_cmp++; if (occ !== 2'd2) begin n_err++; $display("FAIL rstmid_setup_occ: got %0d want 2", occ); end
        br_en = 1'b1; rst = 1'b1; flush = 1'b0; out_ready = 1'b1; in_data = 78'h33;
        step();
        rst = 1'b0; in_valid = 1'b0; br_en = 1'b0;
        n_cmp++; if (occ !== 2'd0)        begin n_err++; $display("FAIL rstmid_occ: got %0d want 0", occ); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
        n_cmp++; if (br_tgt_vld !== 1'b0) begin n_err++; $display("FAIL rstmid_br_vld: got %b want 0", br_tgt_vld); end
        n_cmp++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_data !== '0)     begin n_err++; $display("FAIL rstmid_data: got %h want 0", out_data); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_bubble();
        test_branch();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
